// File: rtl/raystore_arb.sv
// Shares one raystore between NUM_RD round-robin read requesters and two priority-merged write sources.
// RID_W / RAY_W give the widths of rayID_t / ray_vec_t; read responses are routed back by a tag in the sideband MSBs.
module raystore_arb #(
  parameter int NUM_RD   = 3,
  parameter int SB_WIDTH = 8,
  parameter int RID_W    = 8,
  parameter int RAY_W    = 32,
  parameter int TAG_W    = (NUM_RD > 1) ? $clog2(NUM_RD) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD-1:0]            rd_valid,
  input  logic [NUM_RD*RID_W-1:0]      rd_raddr,
  input  logic [NUM_RD*SB_WIDTH-1:0]   rd_sb_data,
  output logic [NUM_RD-1:0]            rd_stall,
  output logic                         rs_us_valid,
  output logic [RID_W-1:0]             rs_raddr,
  output logic [SB_WIDTH+TAG_W-1:0]    rs_us_sb_data,
  input  logic                         rs_us_stall,
  input  logic                         rs_ds_valid,
  input  logic [SB_WIDTH+TAG_W-1:0]    rs_ds_sb_data,
  input  logic [RAY_W-1:0]             rs_ds_rd_data,
  output logic                         rs_ds_stall,
  output logic [NUM_RD-1:0]            ds_valid,
  output logic [SB_WIDTH-1:0]          ds_sb_data,
  output logic [RAY_W-1:0]             ds_rd_data,
  input  logic [NUM_RD-1:0]            ds_stall,
  input  logic                         wa_we,
  input  logic [RID_W-1:0]             wa_waddr,
  input  logic [RAY_W-1:0]             wa_wdata,
  input  logic                         wb_we,
  input  logic [RID_W-1:0]             wb_waddr,
  input  logic [RAY_W-1:0]             wb_wdata,
  output logic                         wb_stall,
  output logic                         rs_we,
  output logic [RID_W-1:0]             rs_waddr,
  output logic [RAY_W-1:0]             rs_wdata
);

  logic                req_v_q, req_v_d;
  logic [RID_W-1:0]    raddr_q, raddr_d;
  logic [SB_WIDTH-1:0] sb_q, sb_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [TAG_W-1:0]    ptr_q, ptr_d;
  logic                we_q, we_d;
  logic [RID_W-1:0]    waddr_q, waddr_d;
  logic [RAY_W-1:0]    wdata_q, wdata_d;

  logic [RID_W-1:0]    raddr_a [NUM_RD];
  logic [SB_WIDTH-1:0] sb_a    [NUM_RD];
  logic                load, gnt_v;
  logic [TAG_W-1:0]    gnt, idx, rsp_tag;

  assign load    = ~req_v_q | ~rs_us_stall;
  assign rsp_tag = rs_ds_sb_data[SB_WIDTH +: TAG_W];

  // Scan downward so the last hit is the nearest requester after ptr.
  always_comb begin
    gnt_v = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = NUM_RD; k >= 1; k--) begin
      idx = TAG_W'((int'(ptr_q) + k) % NUM_RD);
      if (rd_valid[idx]) begin
        gnt_v = 1'b1;
        gnt   = idx;
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_lane
    assign raddr_a[i]  = rd_raddr[i*RID_W +: RID_W];
    assign sb_a[i]     = rd_sb_data[i*SB_WIDTH +: SB_WIDTH];
    assign rd_stall[i] = rd_valid[i] & ~(~rst & load & gnt_v & (gnt == TAG_W'(i)));
    assign ds_valid[i] = rs_ds_valid & (rsp_tag == TAG_W'(i));
  end

  assign ds_sb_data  = rs_ds_sb_data[SB_WIDTH-1:0];
  assign ds_rd_data  = rs_ds_rd_data;
  assign rs_ds_stall = |(ds_valid & ds_stall);

  always_comb begin
    req_v_d = req_v_q;
    raddr_d = raddr_q;
    sb_d    = sb_q;
    tag_d   = tag_q;
    ptr_d   = ptr_q;
    if (load) begin
      req_v_d = gnt_v;
      if (gnt_v) begin
        raddr_d = raddr_a[gnt];
        sb_d    = sb_a[gnt];
        tag_d   = gnt;
        ptr_d   = gnt;
      end
    end
  end

  always_comb begin
    we_d    = wa_we | wb_we;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (wa_we) begin
      waddr_d = wa_waddr;
      wdata_d = wa_wdata;
    end else if (wb_we) begin
      waddr_d = wb_waddr;
      wdata_d = wb_wdata;
    end
  end

  assign wb_stall = wb_we & (wa_we | rst);

  always_ff @(posedge clk) begin
    if (rst) begin
      req_v_q <= 1'b0;
      raddr_q <= '0;
      sb_q    <= '0;
      tag_q   <= '0;
      ptr_q   <= TAG_W'(NUM_RD - 1);
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      req_v_q <= req_v_d;
      raddr_q <= raddr_d;
      sb_q    <= sb_d;
      tag_q   <= tag_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign rs_us_valid   = req_v_q;
  assign rs_raddr      = raddr_q;
  assign rs_us_sb_data = {tag_q, sb_q};
  assign rs_we         = we_q;
  assign rs_waddr      = waddr_q;
  assign rs_wdata      = wdata_q;

endmodule

// File: tb/tb_raystore_arb.sv
// Scoreboard bench for raystore_arb: directed arbitration/routing/write vectors plus a soak against a raystore model.
module tb_raystore_arb;
  localparam int N = 3, SBW = 8, RW = 8, DW = 32, TW = 2;

  logic clk = 1'b0, rst;
  logic [N-1:0] rd_valid, rd_stall, ds_valid, ds_stall;
  logic [N*RW-1:0] rd_raddr;
  logic [N*SBW-1:0] rd_sb_data;
  logic rs_us_valid, rs_us_stall, rs_ds_valid, rs_ds_stall;
  logic [RW-1:0] rs_raddr, wa_waddr, wb_waddr, rs_waddr;
  logic [SBW+TW-1:0] rs_us_sb_data, rs_ds_sb_data;
  logic [DW-1:0] rs_ds_rd_data, ds_rd_data, wa_wdata, wb_wdata, rs_wdata;
  logic [SBW-1:0] ds_sb_data;
  logic wa_we, wb_we, wb_stall, rs_we;

  raystore_arb #(.NUM_RD(N), .SB_WIDTH(SBW), .RID_W(RW), .RAY_W(DW)) dut (
    .clk(clk), .rst(rst), .rd_valid(rd_valid), .rd_raddr(rd_raddr), .rd_sb_data(rd_sb_data),
    .rd_stall(rd_stall), .rs_us_valid(rs_us_valid), .rs_raddr(rs_raddr), .rs_us_sb_data(rs_us_sb_data),
    .rs_us_stall(rs_us_stall), .rs_ds_valid(rs_ds_valid), .rs_ds_sb_data(rs_ds_sb_data),
    .rs_ds_rd_data(rs_ds_rd_data), .rs_ds_stall(rs_ds_stall), .ds_valid(ds_valid),
    .ds_sb_data(ds_sb_data), .ds_rd_data(ds_rd_data), .ds_stall(ds_stall),
    .wa_we(wa_we), .wa_waddr(wa_waddr), .wa_wdata(wa_wdata), .wb_we(wb_we), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata), .wb_stall(wb_stall), .rs_we(rs_we), .rs_waddr(rs_waddr), .rs_wdata(rs_wdata));

  always #5 clk = ~clk;

  typedef struct packed { logic [TW-1:0] tag; logic [SBW-1:0] sb; logic [RW-1:0] addr; } us_t;
  typedef struct packed { logic [RW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct packed { logic [TW-1:0] req; logic [SBW-1:0] sb; logic [DW-1:0] data; } rsp_t;
  typedef struct packed { logic [SBW+TW-1:0] sb; logic [DW-1:0] data; } rs_t;

  localparam logic [RW-1:0]  ADDR [N] = '{8'h11, 8'h2A, 8'h33};
  localparam logic [SBW-1:0] SB   [N] = '{8'hA0, 8'hA1, 8'hA2};

  us_t  us_q[$];
  wr_t  wr_q[$];
  rsp_t exp_q[$];
  rs_t  rs_q[$];
  us_t  ue, un;
  wr_t  we_e, wn;
  rsp_t re, rn;
  rs_t  rsn;
  int   errors = 0, checks = 0, delivered = 0;
  bit   soak = 1'b0;
  logic [N-1:0] held = '0;

  function automatic logic [DW-1:0] fdat(input logic [RW-1:0] a);
    return {~a, a ^ 8'h5A, a, 8'hC3};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_rs();
    rs_ds_valid = (rs_q.size() != 0);
    if (rs_q.size() != 0) begin
      rs_ds_sb_data = rs_q[0].sb;
      rs_ds_rd_data = rs_q[0].data;
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a transfer.
  always @(negedge clk) if (!rst) begin
    if (!soak && rs_us_valid && !rs_us_stall) begin
      if (us_q.size() == 0) chk("us_unexpected", 64'(rs_raddr), 64'hFFFF);
      else begin
        ue = us_q.pop_front();
        chk("us_sb", 64'(rs_us_sb_data), 64'({ue.tag, ue.sb}));
        chk("us_addr", 64'(rs_raddr), 64'(ue.addr));
      end
    end
    if (rs_we) begin
      if (wr_q.size() == 0) chk("wr_unexpected", 64'(rs_waddr), 64'hFFFF);
      else begin
        we_e = wr_q.pop_front();
        chk("wr_addr", 64'(rs_waddr), 64'(we_e.addr));
        chk("wr_data", 64'(rs_wdata), 64'(we_e.data));
      end
    end
    if (soak) begin
      for (int i = 0; i < N; i++) begin
        held[i] = rd_valid[i] & rd_stall[i];
        if (rd_valid[i] && !rd_stall[i]) begin
          rn.req  = TW'(i);
          rn.sb   = rd_sb_data[i*SBW +: SBW];
          rn.data = fdat(rd_raddr[i*RW +: RW]);
          exp_q.push_back(rn);
        end
      end
      if (rs_us_valid && !rs_us_stall) begin
        rsn.sb   = rs_us_sb_data;
        rsn.data = fdat(rs_raddr);
        rs_q.push_back(rsn);
      end
      if (rs_ds_valid) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 64'(ds_valid), 64'h0);
        else begin
          re = exp_q[0];
          chk("rsp_stall", 64'(rs_ds_stall), 64'(ds_stall[re.req]));
          if (!rs_ds_stall) begin
            chk("rsp_route", 64'(ds_valid), 64'(N'(1) << re.req));
            chk("rsp_sb", 64'(ds_sb_data), 64'(re.sb));
            chk("rsp_data", 64'(ds_rd_data), 64'(re.data));
            void'(exp_q.pop_front());
            void'(rs_q.pop_front());
            delivered++;
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; rd_valid = '1; rs_us_stall = 1'b0; rs_ds_valid = 1'b0;
    rs_ds_sb_data = '0; rs_ds_rd_data = '0; ds_stall = '0;
    rd_raddr = {ADDR[2], ADDR[1], ADDR[0]};
    rd_sb_data = {SB[2], SB[1], SB[0]};
    wa_we = 1'b0; wa_waddr = '0; wa_wdata = '0;
    wb_we = 1'b1; wb_waddr = 8'h77; wb_wdata = 32'h1234_5678;

    // Reset: nothing issued, everyone stalled.
    repeat (2) begin
      @(negedge clk);
      chk("rst_us_valid", 64'(rs_us_valid), 64'h0);
      chk("rst_rs_we", 64'(rs_we), 64'h0);
      chk("rst_rd_stall", 64'(rd_stall), 64'h7);
      chk("rst_wb_stall", 64'(wb_stall), 64'h1);
    end
    @(posedge clk); #1;
    rst = 1'b0; wb_we = 1'b0;

    // Round-robin with all valid: 0,1,2,0,1,2.
    for (int k = 0; k < 6; k++) begin
      un.tag = TW'(k % N); un.sb = SB[k % N]; un.addr = ADDR[k % N];
      us_q.push_back(un);
    end
    @(negedge clk);
    chk("first_grant", 64'(rd_stall), 64'h6);
    repeat (6) @(posedge clk);
    #1;

    // Upstream stall: requester 1 issued then held.
    rd_valid = 3'b010;
    un.tag = 2'd1; un.sb = SB[1]; un.addr = 8'h2A;
    us_q.push_back(un);
    @(posedge clk); #1;
    rs_us_stall = 1'b1; rd_valid = 3'b111;
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", 64'(rs_us_valid), 64'h1);
      chk("stall_addr", 64'(rs_raddr), 64'h2A);
      chk("stall_rd_stall", 64'(rd_stall), 64'h7);
    end
    @(posedge clk); #1;
    rs_us_stall = 1'b0;
    un.tag = 2'd2; un.sb = SB[2]; un.addr = ADDR[2];
    us_q.push_back(un);
    @(negedge clk);
    chk("release_grant", 64'(rd_stall), 64'h3);
    @(posedge clk); #1;
    rd_valid = '0;
    repeat (2) @(posedge clk);
    #1;

    // Response routing.
    rs_ds_valid = 1'b1; rs_ds_sb_data = {2'd2, 8'h5C}; rs_ds_rd_data = 32'hDEAD_BEEF; ds_stall = '0;
    #1;
    chk("route_valid", 64'(ds_valid), 64'h4);
    chk("route_sb", 64'(ds_sb_data), 64'h5C);
    chk("route_data", 64'(ds_rd_data), 64'hDEAD_BEEF);
    chk("route_nostall", 64'(rs_ds_stall), 64'h0);
    ds_stall = 3'b100; #1;
    chk("route_stall_own", 64'(rs_ds_stall), 64'h1);
    ds_stall = 3'b001; #1;
    chk("route_stall_other", 64'(rs_ds_stall), 64'h0);
    rs_ds_sb_data = {2'd0, 8'h07}; #1;
    chk("route_tag0", 64'(ds_valid), 64'h1);
    chk("route_tag0_stall", 64'(rs_ds_stall), 64'h1);
    rs_ds_valid = 1'b0; ds_stall = '0; #1;
    chk("route_idle", 64'(ds_valid), 64'h0);

    // Write collision: A wins, B follows.
    @(posedge clk); #1;
    wa_we = 1'b1; wa_waddr = 8'd5; wa_wdata = 32'hAAAA_0005;
    wb_we = 1'b1; wb_waddr = 8'd9; wb_wdata = 32'hBBBB_0009;
    wn.addr = 8'd5; wn.data = 32'hAAAA_0005; wr_q.push_back(wn);
    #1 chk("wb_stall_collide", 64'(wb_stall), 64'h1);
    @(posedge clk); #1;
    wa_we = 1'b0;
    wn.addr = 8'd9; wn.data = 32'hBBBB_0009; wr_q.push_back(wn);
    #1 chk("wb_stall_free", 64'(wb_stall), 64'h0);
    @(posedge clk); #1;
    wb_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Soak against the raystore model.
    soak = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      drive_rs();
      rs_us_stall = ($urandom_range(0, 3) == 0);
      ds_stall = N'($urandom);
      for (int i = 0; i < N; i++) if (!held[i]) begin
        rd_valid[i] = 1'($urandom_range(0, 1));
        rd_raddr[i*RW +: RW] = RW'($urandom);
        rd_sb_data[i*SBW +: SBW] = SBW'($urandom);
      end
    end
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      rd_valid = '0; rs_us_stall = 1'b0; ds_stall = '0;
      drive_rs();
    end
    @(negedge clk);
    chk("soak_exp_empty", 64'(exp_q.size()), 64'h0);
    chk("soak_rs_empty", 64'(rs_q.size()), 64'h0);
    chk("soak_activity", 64'(delivered > 10), 64'h1);
    chk("us_q_empty", 64'(us_q.size()), 64'h0);
    chk("wr_q_empty", 64'(wr_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/raystore_arb.md
# raystore_arb

Arbiter and router that shares a single `raystore_simple` instance among `NUM_RD` read requesters and two write sources. Reads are granted round-robin through a one-entry registered request stage. A requester tag is appended to the raystore sideband so that read responses return to the issuing requester. Writes are merged with fixed priority onto the single raystore write port. The block sits between the traversal/intersection/shader units and the raystore.

## Interface
Parameters:
- `NUM_RD`, default 3: number of read requesters, 2..8.
- `SB_WIDTH`, default 8: per-requester sideband width.
- `TAG_W`, default `$clog2(NUM_RD)`, minimum 1: requester tag width. The raystore is instantiated with sideband width `SB_WIDTH+TAG_W`, and the tag occupies the MSBs.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `rd_valid` in `NUM_RD`: per-requester read request.
- `rd_raddr` in `NUM_RD`×`$bits(rayID_t)`: read address per requester.
- `rd_sb_data` in `NUM_RD`×`SB_WIDTH`: sideband per requester.
- `rd_stall` out `NUM_RD`: request not accepted this cycle. The requester holds its inputs.
- `rs_us_valid` out 1: raystore request valid.
- `rs_raddr` out `$bits(rayID_t)`: raystore read address.
- `rs_us_sb_data` out `SB_WIDTH+TAG_W`: `{tag, sb}`.
- `rs_us_stall` in 1: raystore upstream stall.
- `rs_ds_valid` in 1: raystore response valid.
- `rs_ds_sb_data` in `SB_WIDTH+TAG_W`: response sideband.
- `rs_ds_rd_data` in `ray_vec_t`: response data.
- `rs_ds_stall` out 1: stall to the raystore output.
- `ds_valid` out `NUM_RD`: per-requester response valid.
- `ds_sb_data` out `SB_WIDTH`: response sideband, broadcast to all requesters.
- `ds_rd_data` out `ray_vec_t`: response data, broadcast to all requesters.
- `ds_stall` in `NUM_RD`: per-requester response stall.
- `wa_we`, `wa_waddr` (`rayID_t`), `wa_wdata` (`ray_vec_t`) in: high-priority write source (ray generator).
- `wb_we`, `wb_waddr`, `wb_wdata` in: low-priority write source (shader).
- `wb_stall` out 1: write B not accepted this cycle.
- `rs_we` out 1, `rs_waddr` out `rayID_t`, `rs_wdata` out `ray_vec_t`: raystore write port.

## Operation
- **Request register.** Holds `req_v`, `raddr`, `sb`, `tag`. It drives `rs_us_valid`/`rs_raddr`/`rs_us_sb_data` directly.
- **Load condition.** `load = ~req_v | ~rs_us_stall`.
- **Grant selection.** The grant is the first `i` with `rd_valid[i]`, scanning from `(ptr+1) mod NUM_RD` upward with wrap. The grant is combinational.
- **On `load`:**
  - With a grant: `req_v<=1`, capture that requester's address and sideband, `tag<=i`, `ptr<=i`.
  - With no grant: `req_v<=0`, `ptr` unchanged.
- **Stall output.** `rd_stall[i] = rd_valid[i] & ~(load & grant==i)`. `rd_stall[i]` is 0 when `rd_valid[i]` is 0.
- **Holding under stall.** While `rs_us_stall` is high and `req_v` is 1, the register and `ptr` hold. All valid requesters see stall.
- **Response routing (combinational):**
  - `t = rs_ds_sb_data[MSBs]`.
  - `ds_valid[i] = rs_ds_valid & (t==i)`.
  - `ds_sb_data = rs_ds_sb_data[SB_WIDTH-1:0]`.
  - `ds_rd_data = rs_ds_rd_data`.
  - `rs_ds_stall = rs_ds_valid & ds_stall[t]`.
- **Write merge:**
  - If `wa_we`: register A's address and data, and `wb_stall = wb_we`.
  - Else if `wb_we`: register B's address and data, and `wb_stall = 0`.
  - `rs_we` registers `wa_we | wb_we`.
  - Write A is never stalled.
- **Ordering.** No read/write hazard checking is performed. Callers order dependent accesses.

## Timing
- **Reset values:**
  - `req_v=0`, so `rs_us_valid=0`.
  - `rs_we=0`.
  - `ptr=NUM_RD-1`, so requester 0 wins the first contention.
  - Address, data and sideband registers are 0.
- **Reset is synchronous.** Asserting `rst` mid-operation drops an in-flight held request; it is not replayed. During `rst`, `rd_stall` equals `rd_valid` and `wb_stall` equals `wb_we`.
- **Read request latency.** Accepted at edge t, the request is presented to the raystore in cycle t+1. Back-to-back issue runs at 1 per cycle with no bubble while `rs_us_stall` is low.
- **Fairness.** With all requesters continuously valid, grants cycle 0,1,…,`NUM_RD-1`,0. No requester waits more than `NUM_RD-1` grants.
- **Response path latency.** Zero cycles, pure combinational.
- **Write latency.** 1 cycle from input to `rs_we`.
- **Simultaneous writes.** When `wa_we` and `wb_we` are asserted in the same cycle, A is written and B is stalled. B is issued the next cycle if A is idle.

## Test plan
- **Reset.** Assert `rst` 2 cycles with all `rd_valid=1`. Required: `rs_us_valid=0`, `rs_we=0`, and `rd_stall` equals `rd_valid`. The first cycle after reset grants requester 0.
- **Round-robin.** With `NUM_RD=3`, hold all `rd_valid=1` for 6 cycles, `rs_us_stall=0`. Required: `rs_us_sb_data` tags 0,1,2,0,1,2 on consecutive cycles, each carrying the matching `rd_raddr`.
- **Upstream stall.** Issue requester 1 (addr 0x2A), then hold `rs_us_stall=1` for 3 cycles. Required: `rs_raddr` holds 0x2A, all `rd_stall` bits equal `rd_valid`, and `ptr` is unchanged. On release, the next grant is requester 2.
- **Response routing.**
  - Drive `rs_ds_valid=1` with tag 2, `sb=0x5C`. Required: only `ds_valid[2]=1`, `ds_sb_data=0x5C`.
  - Then set `ds_stall[2]=1`. Required: `rs_ds_stall=1`.
  - Then set `ds_stall[0]=1` only. Required: `rs_ds_stall=0`.
- **Write collision.** Drive `wa_we=wb_we=1` with A addr 5 and B addr 9. Required: `wb_stall=1`, and the next cycle shows `rs_we=1`, `rs_waddr=5`. With `wa_we=0` and B held, the following cycle shows `rs_waddr=9`.
- **Random soak.** Apply 100 cycles of random `rd_valid`/`rs_us_stall` against a raystore model. Required: every accepted request returns exactly once, to its issuer, with data equal to the model contents.
